// File: rtl/ii_pkg.sv
// Shared defaults, FSM encoding and the integral adder for the integral-image writer.
// II_SATURATE_EN selects clamping adds instead of modulo-2**SUM_W wrap-around.
package ii_pkg;

  localparam int MAX_W  = 240;
  localparam int PIX_W  = 8;
  localparam int SUM_W  = 32;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ii_state_e;

  // Operands are zero-extended to 64 bits; sum_w is the integral word width (<= 32).
  function automatic logic [63:0] ii_add(input logic [63:0] a, input logic [63:0] b, input int sum_w);
    logic [63:0] mask_v;
    logic [63:0] sum_v;
    mask_v = (64'd1 << sum_w) - 64'd1;
    sum_v  = a + b;
`ifdef II_SATURATE_EN
    if (sum_v > mask_v) begin
      ii_add = mask_v;
    end else begin
      ii_add = sum_v;
    end
`else
    ii_add = sum_v & mask_v;
`endif
  endfunction

  function automatic logic ii_sat_hit(input logic [63:0] a, input logic [63:0] b, input int sum_w);
    logic [63:0] mask_v;
    mask_v     = (64'd1 << sum_w) - 64'd1;
    ii_sat_hit = ((a + b) > mask_v);
  endfunction

endpackage

// File: rtl/ii_line_buf.sv
// One-row line buffer holding the previous row's integral values.
// The read at idx is combinational, so it returns the old word while the same index is rewritten.
module ii_line_buf #(
  parameter int DEPTH = ii_pkg::MAX_W,
  parameter int WIDTH = ii_pkg::SUM_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Row storage; contents need no reset because row 0 never reads it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[idx];

endmodule

// File: rtl/integral_image_writer.sv
// Streams a raster tile of pixels and writes ii(x,y) to the core image memory at y*width+x.
// Optional build macro: II_SATURATE_EN (clamping adds plus a sticky sat_seen output).
module integral_image_writer #(
  parameter int MAX_W  = ii_pkg::MAX_W,
  parameter int PIX_W  = ii_pkg::PIX_W,
  parameter int SUM_W  = ii_pkg::SUM_W,
  parameter int ADDR_W = ii_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_height,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SUM_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef II_SATURATE_EN
  ,
  output logic              sat_seen
`endif
);

  import ii_pkg::*;

  localparam int LB_AW = $clog2(MAX_W);

  ii_state_e         state_r;
  ii_state_e         next_state_s;
  logic [15:0]       width_r;
  logic [15:0]       height_r;
  logic [15:0]       x_r;
  logic [15:0]       y_r;
  logic [ADDR_W-1:0] addr_r;
  logic [SUM_W-1:0]  row_sum_r;
  logic [SUM_W-1:0]  rs_base_s;
  logic [SUM_W-1:0]  row_sum_s;
  logic [SUM_W-1:0]  lb_rd_s;
  logic [SUM_W-1:0]  lb_base_s;
  logic [SUM_W-1:0]  ii_s;
  logic [31:0]       area_s;
  logic              cfg_ok_s;
  logic              start_ok_s;
  logic              accept_s;
  logic              x_last_s;
  logic              last_pix_s;
  logic              busy_s;
  logic              ready_s;
  logic              done_s;
  logic              cfg_err_s;
`ifdef II_SATURATE_EN
  logic              sat_hit_s;
`endif

  assign area_s     = 32'(cfg_width) * 32'(cfg_height);
  assign cfg_ok_s   = (cfg_width  >= 16'd1) && (cfg_width  <= 16'(MAX_W)) &&
                      (cfg_height >= 16'd1) && (cfg_height <= 16'(MAX_W)) &&
                      (area_s <= (32'd1 << ADDR_W));
  assign start_ok_s = start && (state_r == IDLE) && cfg_ok_s;
  assign accept_s   = pix_valid && pix_ready;
  assign x_last_s   = (x_r == (width_r - 16'd1));
  assign last_pix_s = x_last_s && (y_r == (height_r - 16'd1));

  ii_line_buf #(
    .DEPTH (MAX_W),
    .WIDTH (SUM_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (accept_s),
    .idx     (x_r[LB_AW-1:0]),
    .wr_data (ii_s),
    .rd_data (lb_rd_s)
  );

  // Row accumulation and vertical add for the pixel at (x_r, y_r)
  always_comb begin
    rs_base_s = {SUM_W{1'b0}};
    lb_base_s = {SUM_W{1'b0}};
    if (x_r != 16'd0) begin
      rs_base_s = row_sum_r;
    end else begin
      rs_base_s = {SUM_W{1'b0}};
    end
    if (y_r != 16'd0) begin
      lb_base_s = lb_rd_s;
    end else begin
      lb_base_s = {SUM_W{1'b0}};
    end
    row_sum_s = SUM_W'(ii_add(64'(rs_base_s), 64'(pix_data), SUM_W));
    ii_s      = SUM_W'(ii_add(64'(row_sum_s), 64'(lb_base_s), SUM_W));
`ifdef II_SATURATE_EN
    sat_hit_s = ii_sat_hit(64'(rs_base_s), 64'(pix_data), SUM_W) ||
                ii_sat_hit(64'(row_sum_s), 64'(lb_base_s), SUM_W);
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && cfg_ok_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_pix_s) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = RUN;
        end
      end
      FLUSH:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead of the output register stage
  always_comb begin
    done_s    = 1'b0;
    cfg_err_s = 1'b0;
    case (state_r)
      IDLE:    cfg_err_s = start && !cfg_ok_s;
      FLUSH:   done_s    = 1'b1;
      default: done_s    = 1'b0;
    endcase
    busy_s  = (next_state_s != IDLE);
    ready_s = (next_state_s == RUN);
  end

  // Geometry latch, raster counters and running row sum; the address is a +1 counter, not y*W+x
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_r   <= 16'd0;
      height_r  <= 16'd0;
      x_r       <= 16'd0;
      y_r       <= 16'd0;
      addr_r    <= {ADDR_W{1'b0}};
      row_sum_r <= {SUM_W{1'b0}};
    end else if (start_ok_s) begin
      width_r   <= cfg_width;
      height_r  <= cfg_height;
      x_r       <= 16'd0;
      y_r       <= 16'd0;
      addr_r    <= {ADDR_W{1'b0}};
      row_sum_r <= {SUM_W{1'b0}};
    end else if (accept_s) begin
      row_sum_r <= row_sum_s;
      addr_r    <= addr_r + ADDR_W'(1);
      if (x_last_s) begin
        x_r <= 16'd0;
        y_r <= y_r + 16'd1;
      end else begin
        x_r <= x_r + 16'd1;
      end
    end
  end

  // Registered output stage: the write appears one cycle after the pixel is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
      wr_data   <= {SUM_W{1'b0}};
    end else begin
      pix_ready <= ready_s;
      busy      <= busy_s;
      done      <= done_s;
      cfg_err   <= cfg_err_s;
      wr_en     <= accept_s;
      if (accept_s) begin
        wr_addr <= addr_r;
        wr_data <= ii_s;
      end
    end
  end

`ifdef II_SATURATE_EN
  // Sticky clamp indicator, cleared when a new frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_seen <= 1'b0;
    end else if (start_ok_s) begin
      sat_seen <= 1'b0;
    end else if (accept_s && sat_hit_s) begin
      sat_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_integral_image_writer.sv
// Scoreboard bench for integral_image_writer: stimulus pushes expected writes, a monitor pops them.
// With II_SATURATE_EN defined the DUT is built with 10-bit sums and clamping is exercised.
module tb_integral_image_writer;

`ifdef II_SATURATE_EN
  localparam int TW = 10;
`else
  localparam int TW = 32;
`endif
  localparam int AW = 17;
  localparam int PW = 8;
  localparam int MW = 240;
  localparam longint unsigned MAXV = (64'd1 << TW) - 64'd1;

  typedef struct {
    int unsigned     addr;
    longint unsigned data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   cfg_width = 16'd0;
  logic [15:0]   cfg_height = 16'd0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_data = 8'd0;
  logic          pix_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef II_SATURATE_EN
  logic          sat_seen;
`endif

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned frame_pix[$];
  bit          frame_sat;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          done_cnt = 0;

  integral_image_writer #(
    .MAX_W  (MW),
    .PIX_W  (PW),
    .SUM_W  (TW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef II_SATURATE_EN
    ,
    .sat_seen   (sat_seen)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Monitor: compares every write against the scoreboard and times the done pulse
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && wr_en) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write addr=%0d data=%0d, no write expected", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== AW'(mon_e.addr) || wr_data !== TW'(mon_e.data)) begin
          errors = errors + 1;
          $display("FAIL write addr=%0d data=%0d, expected addr=%0d data=%0d",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
      last_wr_cyc = cyc;
    end
    if (!reset && done) begin
      checks = checks + 1;
      done_cnt = done_cnt + 1;
      if (cyc != last_wr_cyc + 1) begin
        errors = errors + 1;
        $display("FAIL done_timing done at cycle %0d, expected %0d", cyc, last_wr_cyc + 1);
      end
    end
  end

  task automatic check_eq(input string name, input longint unsigned act, input longint unsigned expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference: ii is the plain 2-D prefix sum, reduced modulo 2**TW or clamped at 2**TW-1
  task automatic push_expected(input int w, input int idx);
    int              x;
    int              y;
    longint unsigned s;
    exp_t            e;
    x = idx % w;
    y = idx / w;
    s = 64'd0;
    for (int j = 0; j <= y; j++) begin
      for (int i = 0; i <= x; i++) begin
        s = s + 64'(frame_pix[j * w + i]);
      end
    end
`ifdef II_SATURATE_EN
    if (s > MAXV) begin
      frame_sat = 1'b1;
      s = MAXV;
    end
`else
    s = s & MAXV;
`endif
    e.addr = int'(y * w + x);
    e.data = s;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int w, input int h);
    cfg_width  = 16'(w);
    cfg_height = 16'(h);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // pat: 0 all ones, 1 raster index, 2 random, 3 all 255; gap: 0 none, 1 toggle, 2 random
  task automatic run_frame(input int w, input int h, input int pat, input int gap,
                           input int stop_after, input bit poke);
    int n;
    int lim;
    int idx;
    int it;
    int d0;
    bit skip;
    n   = w * h;
    lim = (stop_after > 0) ? stop_after : n;
    idx = 0;
    it  = 0;
    d0  = done_cnt;
    frame_pix.delete();
    frame_sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       frame_pix.push_back(1);
        1:       frame_pix.push_back(i % 256);
        2:       frame_pix.push_back($urandom_range(0, 255));
        default: frame_pix.push_back(255);
      endcase
    end
    do_start(w, h);
    while (idx < lim && it < 4 * lim + 50) begin
      if (gap == 1) skip = (it % 2 == 1);
      else if (gap == 2) skip = ($urandom_range(0, 2) == 0);
      else skip = 1'b0;
      if (poke && it == 1) begin
        start     = 1'b1;
        cfg_width = 16'd0;
      end
      if (skip) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data  = PW'(frame_pix[idx]);
        if (pix_ready) begin
          push_expected(w, idx);
          idx = idx + 1;
        end
      end
      @(posedge clk); #1;
      it = it + 1;
      if (start) begin
        start = 1'b0;
        check_eq("start_while_busy_cfg_err", 64'(cfg_err), 64'd0);
      end
    end
    pix_valid = 1'b0;
    check_eq("pixels_accepted", 64'(idx), 64'(lim));
    if (stop_after == 0) begin
      for (int k = 0; k < 8 && done_cnt == d0; k++) begin
        @(posedge clk); #1;
      end
      check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
      check_eq("busy_after_done", 64'(busy), 64'd0);
      check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef II_SATURATE_EN
      check_eq("sat_seen", 64'(sat_seen), 64'(frame_sat));
`endif
    end
  endtask

  task automatic bad_cfg(input int w, input int h);
    do_start(w, h);
    check_eq("bad_cfg_err_pulse", 64'(cfg_err), 64'd1);
    check_eq("bad_cfg_busy", 64'(busy), 64'd0);
    check_eq("bad_cfg_ready", 64'(pix_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("bad_cfg_err_cleared", 64'(cfg_err), 64'd0);
    check_eq("bad_cfg_busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check_eq({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    check_eq({tag, "_pix_ready"}, 64'(pix_ready), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Pixels offered while idle must not be taken
    pix_valid = 1'b1;
    pix_data  = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_pix_ready", 64'(pix_ready), 64'd0);
    pix_valid = 1'b0;

    run_frame(3, 3, 0, 0, 0, 1'b0);
    run_frame(4, 2, 1, 0, 0, 1'b1);
    run_frame(3, 3, 0, 1, 0, 1'b0);

    bad_cfg(0, 3);
    bad_cfg(MW + 1, 3);
    bad_cfg(3, 0);
    bad_cfg(3, MW + 1);

    // Reset after the fourth pixel of a 3x3 frame, then a clean restart
    run_frame(3, 3, 0, 0, 4, 1'b0);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
`ifdef II_SATURATE_EN
    check_eq("midreset_sat_seen", 64'(sat_seen), 64'd0);
`endif
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(3, 3, 0, 0, 0, 1'b0);

    run_frame(1, 1, 2, 0, 0, 1'b0);
    run_frame(MW, 2, 2, 2, 0, 1'b0);
    run_frame(1, MW, 1, 0, 0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 2,
                int'($urandom_range(0, 2)), 0, 1'b0);
    end

`ifdef II_SATURATE_EN
    run_frame(2, 2, 3, 0, 0, 1'b0);
    run_frame(3, 3, 3, 0, 0, 1'b0);
    run_frame(1, 1, 0, 0, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
